jtopl_chcfg: RTL and testbench
==============================

# jtopl_chcfg

Parametrised channel-configuration sequencer for OPL2/OPL3-class synthesis cores. It runs the operator slot counter for 9 or 18 channels and stores per-channel frequency/feedback/connection/key-on state in per-group rotating rings. It applies host register writes at the matching slot through a pending-request handshake. It also produces rhythm-mode key-on/connection overrides and, optionally, OPL3 4-operator pairing. It sits between the register decoder and the PG/EG/OP pipeline.

## Interface
Parameters:
- CH, 9: channel count; legal values 9 or 18. G=CH/3 groups, 2*CH slots.
- GW, derived: group index width, max(2,$clog2(G)).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  clock enable; counter and rings advance only when high
- din  in  8  register data byte
- sel_ch  in  5  target channel, 0..CH-1
- up_fnumlo / up_fnumhi / up_fbcon  in  1 each  one-clk write strobes
- busy  out  1  write request pending
- rhy_en  in  1  rhythm mode
- rhy_kon  in  5  rhythm key-ons {BD,SD,TOM,TC,HH}, bits 4..0
- con4  in  6  4-op enables: bits 0-2 bank 0 pairs, bits 3-5 bank 1 pairs
- zero  out  1  high at slot 0
- group  out  GW  current group
- sub  out  3  current subslot, 0..5
- op  out  1  1 for carrier slots (sub>=3)
- fnum_I  out  10;  block_I  out  3;  fb_I  out  3
- con_I  out  1;  keyon_I  out  1
- pair_I  out  1  current channel belongs to an active 4-op pair
- sec_I  out  1  current channel is the pair's secondary

## Operation
- Slot order: group 0..G-1, sub 0..5 within each group. Channel = 3*group + (sub mod 3). Slot index = 6*group+sub; it wraps 2*CH-1 -> 0.
- Channel record, 18 bits: {keyon, block[2:0], fnum[9:0], fb[2:0], con}.
- Each group has a 3-entry ring that rotates on every cen. Ring input equals ring output except in the current group, where it equals the write-muxed record.
- The _I outputs present the current group's ring head.
- Write handshake:
  - Any up_* strobe captures din, sel_ch and the strobe mask, then sets busy.
  - A strobe while busy overwrites the pending request; last wins.
  - The request is applied at the first cen slot whose channel equals sel_ch and sub<3. busy clears on that edge.
  - A strobe on that same edge becomes the new pending request.
- Fields updated by each strobe:
  - up_fnumlo: fnum[7:0]=din.
  - up_fnumhi: {keyon,block,fnum[9:8]}=din[5:0].
  - up_fbcon: fb=din[3:1], con=din[0].
  - Multiple strobes in one clk update all flagged fields from the same din.
  - sel_ch>=CH is never applied; it holds busy until overwritten.
- Rhythm, group 2 only, sampled at slot 11:
  - keyon_I per sub 0..5 is BD, HH, TOM, BD, SD, TC.
  - con_I is forced 1 on subs 2..5.
  - rhy_kon is latched at slot 11 for slots 12..17.

## Timing
- Reset values:
  - slot index 0; group=0, sub=0, zero=1, op=0, busy=0.
  - All ring records 0, so all _I outputs are 0.
  - Pending request cleared.
- Reset mid-request drops the request.
- A written field appears on the _I outputs 3 cen cycles after the apply slot (the carrier slot of the same channel), and on every later visit.
- Worst-case busy time: 2*CH cen cycles plus 1 clk.
- Outputs are combinational from registered state; no extra latency versus group/sub.

## Configuration
- JTOPL_4OP_EN defined:
  - Channel n (n=0..2 within bank b, bank = 9-channel half) pairs with n+3 when con4[3b+n]=1.
  - pair_I=1 on both channels of an active pair; sec_I=1 on the secondary.
  - The secondary's keyon_I equals the primary's keyon, latched at the primary's sub-0 slot of the same frame.
  - con4 is sampled at slot 0.
- Undefined: con4 ignored, pair_I=sec_I=0, keyon_I from the channel's own record.
- Rhythm override takes precedence over pairing.

## Structure
- jtopl_pkg holds:
  - record field widths and the CHCSRW=18 constant;
  - rhythm indices BD=4, SD=3, TOM=2, TC=1, HH=0;
  - the rhythm subslot sequence.
- Sub-module jtopl_ch_ring: parametrised-width 3-stage rotating ring with async reset, instantiated G times.

## Test plan
- Reset, CH=18, free-run cen -> zero pulses every 36 cen; group runs 0..5; op high on subs 3..5.
- up_fnumlo din=0xA5, sel_ch=4 -> busy high until slot 7; fnum_I[7:0]=0xA5 from slot 10 on, and every frame.
- Two strobes while busy (sel_ch=1, then sel_ch=2 with up_fbcon din=0x0B) -> only ch 2 gets fb=5, con=1; ch 1 unchanged.
- rhy_en=1, rhy_kon=5'b10001 -> keyon_I=1 at slots 12, 13 and 15 only; con_I=1 at slots 14..17.
- JTOPL_4OP_EN, con4=6'b000001, up_fnumhi din=0x20 on ch 0 -> keyon_I=1 at ch 0 and ch 3 slots; pair_I=1 on both; sec_I=1 on ch 3.
- rst asserted while busy -> busy=0 and all _I outputs 0 after release; the dropped write never appears.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared definitions for the jtopl channel-configuration slice: channel record
// layout, rhythm instrument indices and the rhythm subslot sequence.
package jtopl_pkg;

    localparam int FNUM_W = 10;
    localparam int BLK_W  = 3;
    localparam int FB_W   = 3;
    localparam int CHCSRW = 18;

    localparam int RHY_BD  = 4;
    localparam int RHY_SD  = 3;
    localparam int RHY_TOM = 2;
    localparam int RHY_TC  = 1;
    localparam int RHY_HH  = 0;

    typedef struct packed {
        logic              keyon;
        logic [BLK_W-1:0]  block;
        logic [FNUM_W-1:0] fnum;
        logic [FB_W-1:0]   fb;
        logic              con;
    } ch_rec_t;

    // Rhythm instrument that owns each subslot of group 2
    function automatic logic [2:0] rhy_sel(input logic [2:0] sub);
        case (sub)
            3'd0:    rhy_sel = 3'(RHY_BD);
            3'd1:    rhy_sel = 3'(RHY_HH);
            3'd2:    rhy_sel = 3'(RHY_TOM);
            3'd3:    rhy_sel = 3'(RHY_BD);
            3'd4:    rhy_sel = 3'(RHY_SD);
            default: rhy_sel = 3'(RHY_TC);
        endcase
    endfunction

endpackage

// File: rtl/jtopl_ch_ring.sv
// Three-stage rotating ring holding the records of the three channels of one
// group; q is the record of the channel owning the current slot.
module jtopl_ch_ring #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r0, r1, r2;

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else if (cen) begin
            r0 <= r1;
            r1 <= r2;
            r2 <= d;
        end
    end

    assign q = r0;

endmodule

// File: rtl/jtopl_chcfg.sv
// Channel-configuration sequencer: slot counter, per-group record rings, host
// write handshake and rhythm overrides. Define JTOPL_4OP_EN for OPL3 4-op pairing.
module jtopl_chcfg
    import jtopl_pkg::*;
#(
    parameter int CH = 9,
    parameter int GW = ($clog2(CH/3) > 2) ? $clog2(CH/3) : 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [7:0]    din,
    input  logic [4:0]    sel_ch,
    input  logic          up_fnumlo,
    input  logic          up_fnumhi,
    input  logic          up_fbcon,
    output logic          busy,
    input  logic          rhy_en,
    input  logic [4:0]    rhy_kon,
    input  logic [5:0]    con4,
    output logic          zero,
    output logic [GW-1:0] group,
    output logic [2:0]    sub,
    output logic          op,
    output logic [9:0]    fnum_I,
    output logic [2:0]    block_I,
    output logic [2:0]    fb_I,
    output logic          con_I,
    output logic          keyon_I,
    output logic          pair_I,
    output logic          sec_I
);

    localparam int G = CH / 3;

    logic [GW-1:0] grp;
    logic [2:0]    sb;
    logic [1:0]    sub_m3;
    logic [4:0]    cur_ch;

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            grp <= '0;
            sb  <= '0;
        end else if (cen) begin
            if (sb == 3'd5) begin
                sb  <= '0;
                grp <= (grp == GW'(G-1)) ? '0 : grp + GW'(1);
            end else begin
                sb <= sb + 3'd1;
            end
        end
    end

    assign sub_m3 = (sb >= 3'd3) ? 2'(sb - 3'd3) : sb[1:0];
    assign cur_ch = 5'(grp) * 5'd3 + 5'(sub_m3);
    assign group  = grp;
    assign sub    = sb;
    assign zero   = (grp == '0) && (sb == 3'd0);
    assign op     = (sb >= 3'd3);

    // Write handshake: any up_* strobe loads the request and raises busy; busy
    // drops on the cen edge that applies it, unless a strobe on that edge reloads it.
    logic [7:0] req_din;
    logic [4:0] req_ch;
    logic [2:0] req_mask;
    logic [2:0] strobes;
    logic       apply;

    assign strobes = {up_fbcon, up_fnumhi, up_fnumlo};
    assign apply   = cen && busy && (cur_ch == req_ch) && (sb < 3'd3);

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            req_din  <= '0;
            req_ch   <= '0;
            req_mask <= '0;
        end else begin
            if (apply)
                busy <= 1'b0;
            if (|strobes) begin
                busy     <= 1'b1;
                req_din  <= din;
                req_ch   <= sel_ch;
                req_mask <= strobes;
            end
        end
    end

    ch_rec_t ring_q [G];
    ch_rec_t ring_d [G];
    ch_rec_t head;
    ch_rec_t wr_rec;

    always_comb begin
        head = '0;
        for (int i = 0; i < G; i++)
            if (grp == GW'(i))
                head = ring_q[i];
    end

    always_comb begin
        wr_rec = head;
        if (apply) begin
            if (req_mask[0])
                wr_rec.fnum[7:0] = req_din;
            if (req_mask[1])
                {wr_rec.keyon, wr_rec.block, wr_rec.fnum[9:8]} = req_din[5:0];
            if (req_mask[2])
                {wr_rec.fb, wr_rec.con} = req_din[3:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < G; gi++) begin : g_ring
            assign ring_d[gi] = (grp == GW'(gi)) ? wr_rec : ring_q[gi];
            jtopl_ch_ring #(.W(CHCSRW)) u_ring (
                .clk (clk),
                .rst (rst),
                .cen (cen),
                .d   (ring_d[gi]),
                .q   (ring_q[gi])
            );
        end
    endgenerate

    // Rhythm key-ons are frozen at the last slot before group 2 starts
    logic [4:0] rhy_lat;

    always_ff @(posedge clk, posedge rst) begin
        if (rst)
            rhy_lat <= '0;
        else if (cen && (grp == GW'(1)) && (sb == 3'd5))
            rhy_lat <= rhy_kon;
    end

`ifdef JTOPL_4OP_EN
    logic [5:0] c4_lat;
    logic [5:0] c4_eff;
    logic [5:0] pkon;
    logic       bank;
    logic [2:0] pidx;
    logic       is_pri;
    logic       is_sec;

    assign bank   = (grp >= GW'(3));
    assign pidx   = bank ? 3'(sub_m3) + 3'd3 : 3'(sub_m3);
    assign is_pri = (grp == GW'(0)) || (grp == GW'(3));
    assign is_sec = (grp == GW'(1)) || (grp == GW'(4));
    assign c4_eff = zero ? con4 : c4_lat;

    // Primary key-on is captured at its modulator slot for the secondary later in the frame
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            c4_lat <= '0;
            pkon   <= '0;
        end else if (cen) begin
            if (zero)
                c4_lat <= con4;
            if (is_pri && (sb < 3'd3))
                pkon[pidx] <= head.keyon;
        end
    end
`else
    logic unused_con4;
    assign unused_con4 = ^con4;
`endif

    always_comb begin
        fnum_I  = head.fnum;
        block_I = head.block;
        fb_I    = head.fb;
        con_I   = head.con;
        keyon_I = head.keyon;
        pair_I  = 1'b0;
        sec_I   = 1'b0;
`ifdef JTOPL_4OP_EN
        pair_I = (is_pri || is_sec) && c4_eff[pidx];
        sec_I  = is_sec && c4_eff[pidx];
        if (sec_I)
            keyon_I = pkon[pidx];
`endif
        if (rhy_en && (grp == GW'(2))) begin
            keyon_I = rhy_lat[rhy_sel(sb)];
            if (sb >= 3'd2)
                con_I = 1'b1;
        end
    end

endmodule

// File: tb/tb_jtopl_chcfg.sv
// Randomised bench for jtopl_chcfg (CH=18) against a slot-level channel model.
// Define JTOPL_4OP_EN for both RTL and bench to exercise 4-op pairing.
module tb_jtopl_chcfg;
  import jtopl_pkg::*;

  localparam int CH    = 18;
  localparam int NSLOT = 2 * CH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic [7:0] din = '0;
  logic [4:0] sel_ch = '0;
  logic       up_fnumlo = 1'b0, up_fnumhi = 1'b0, up_fbcon = 1'b0;
  logic       busy;
  logic       rhy_en = 1'b0;
  logic [4:0] rhy_kon = '0;
  logic [5:0] con4 = '0;
  logic       zero, op, con_I, keyon_I, pair_I, sec_I;
  logic [2:0] group, sub, block_I, fb_I;
  logic [9:0] fnum_I;

  jtopl_chcfg #(.CH(CH)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .sel_ch(sel_ch),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
    .busy(busy), .rhy_en(rhy_en), .rhy_kon(rhy_kon), .con4(con4),
    .zero(zero), .group(group), .sub(sub), .op(op),
    .fnum_I(fnum_I), .block_I(block_I), .fb_I(fb_I),
    .con_I(con_I), .keyon_I(keyon_I), .pair_I(pair_I), .sec_I(sec_I)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         t;
  ch_rec_t    m_rec [CH];
  logic       m_busy;
  logic [7:0] m_din;
  logic [4:0] m_ch;
  logic [2:0] m_mask;
  logic [4:0] m_rhy;
  logic [5:0] m_c4;
  logic [5:0] m_pkon;
  logic [20:0] exp_q[$];
  int rmap [6] = '{4, 0, 2, 4, 3, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (slot %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < CH; i++) m_rec[i] = '0;
    m_busy = 1'b0; m_din = '0; m_ch = '0; m_mask = '0;
    m_rhy = '0; m_c4 = '0; m_pkon = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    int g, s, c;
    ch_rec_t r;
    logic ek, econ, ep, es;
    g = t / 6; s = t % 6; c = 3 * g + s % 3;
    r = m_rec[c];
    ek = r.keyon; econ = r.con; ep = 1'b0; es = 1'b0;
`ifdef JTOPL_4OP_EN
    begin
      int b, n;
      logic [5:0] c4;
      c4 = (t == 0) ? con4 : m_c4;
      b = c / 9; n = c % 9;
      if (n < 3) ep = c4[3*b+n];
      else if (n < 6) begin
        ep = c4[3*b+n-3];
        es = ep;
        if (es) ek = m_pkon[3*b+n-3];
      end
    end
`endif
    if (rhy_en && g == 2) begin
      ek = m_rhy[rmap[s]];
      if (s >= 2) econ = 1'b1;
    end
    check("zero", 32'(zero), 32'(t == 0));
    check("group", 32'(group), 32'(g));
    check("sub", 32'(sub), 32'(s));
    check("op", 32'(op), 32'(s >= 3));
    check("busy", 32'(busy), 32'(m_busy));
    check("fnum", 32'(fnum_I), 32'(r.fnum));
    check("block", 32'(block_I), 32'(r.block));
    check("fb", 32'(fb_I), 32'(r.fb));
    check("con", 32'(con_I), 32'(econ));
    check("keyon", 32'(keyon_I), 32'(ek));
    check("pair", 32'(pair_I), 32'(ep));
    check("sec", 32'(sec_I), 32'(es));
    if (cen && s >= 3 && exp_q.size() > 0 && int'(exp_q[0][20:16]) == c) begin
      check("sb_rec", 32'({fnum_I, block_I, fb_I}), 32'(exp_q[0][15:0]));
      void'(exp_q.pop_front());
    end
  endtask

  task automatic model_update();
    int g, s, c;
    ch_rec_t r;
    g = t / 6; s = t % 6; c = 3 * g + s % 3;
    if (cen) begin
`ifdef JTOPL_4OP_EN
      if (t == 0) m_c4 = con4;
      if ((g == 0 || g == 3) && s < 3) m_pkon[3*(g/3)+s] = m_rec[c].keyon;
`endif
      if (t == 11) m_rhy = rhy_kon;
      if (m_busy && int'(m_ch) == c && s < 3) begin
        r = m_rec[c];
        if (m_mask[0]) r.fnum[7:0] = m_din;
        if (m_mask[1]) {r.keyon, r.block, r.fnum[9:8]} = m_din[5:0];
        if (m_mask[2]) {r.fb, r.con} = m_din[3:0];
        m_rec[c] = r;
        exp_q.push_back({5'(c), r.fnum, r.block, r.fb});
        m_busy = 1'b0;
      end
      t = (t + 1) % NSLOT;
    end
    if (up_fnumlo | up_fnumhi | up_fbcon) begin
      m_din = din; m_ch = sel_ch;
      m_mask = {up_fbcon, up_fnumhi, up_fnumlo};
      m_busy = 1'b1;
    end
  endtask

  // one clock: drive at the falling edge, check 1 ns later, model the rising edge
  task automatic tick(input logic c_en, input logic [2:0] strb, input logic [7:0] d, input logic [4:0] ch);
    cen = c_en;
    {up_fbcon, up_fnumhi, up_fnumlo} = strb;
    din = d;
    sel_ch = ch;
    #1;
    check_outputs();
    model_update();
    @(negedge clk);
    {up_fbcon, up_fnumhi, up_fnumlo} = 3'b000;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 3'b000, 8'h00, 5'd0);
  endtask

  task automatic goto_slot(input int target);
    for (int k = 0; k < NSLOT && t != target; k++) tick(1'b1, 3'b000, 8'h00, 5'd0);
  endtask

  task automatic reset_dut();
    cen = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state, then free-running slot counter
    tick(1'b0, 3'b000, 8'h00, 5'd0);
    idle(80);

    // single fnum low write to channel 4
    goto_slot(0);
    tick(1'b1, 3'b001, 8'hA5, 5'd4);
    idle(80);

    // overwrite while busy: only channel 2 gets fb/con
    goto_slot(2);
    tick(1'b1, 3'b001, 8'($urandom), 5'd1);
    tick(1'b1, 3'b100, 8'h0B, 5'd2);
    idle(80);

    // rhythm mode
    rhy_en = 1'b1;
    rhy_kon = 5'b10001;
    idle(80);
    rhy_en = 1'b0;

    // 4-op pairing of channels 0 and 3
    con4 = 6'b000001;
    goto_slot(20);
    tick(1'b1, 3'b010, 8'h20, 5'd0);
    idle(120);
    con4 = 6'b000000;
    idle(40);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      logic [2:0] strb;
      strb = 3'b000;
      if ((!m_busy && $urandom_range(0, 3) == 0) || $urandom_range(0, 15) == 0)
        strb = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 63) == 0) rhy_en = 1'($urandom);
      if ($urandom_range(0, 31) == 0) rhy_kon = 5'($urandom);
      if ($urandom_range(0, 63) == 0) con4 = 6'($urandom);
      tick(1'($urandom_range(0, 3) != 0), strb, 8'($urandom), 5'($urandom_range(0, 19)));
    end
    rhy_en = 1'b0;
    idle(40);

    // reset while busy drops the request
    goto_slot(20);
    tick(1'b1, 3'b111, 8'hFF, 5'd1);
    idle(2);
    reset_dut();
    tick(1'b0, 3'b000, 8'h00, 5'd0);
    idle(80);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
